// File: rtl/cdt_arb_pkg.sv
// Shared types and helpers for countdown_timer_arbiter.
//   cdt_state_e : controller state encoding (IDLE, LOAD, RUN, DONE)
//   rr_next_idx : round-robin pointer advance with wrap at n-1 (n need not be a power of two)
package cdt_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cdt_state_e;

  function automatic int rr_next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: the search starts at ptr and wraps; the first set bit wins.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IDXW  highest-priority index (must be < NREQ)
//   gnt_oh  out NREQ  one-hot winner (zero when no request)
//   gnt_idx out IDXW  winner index (zero when no request)
//   vld     out 1     a winner exists
module rr_arbiter_onehot #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDXW-1:0] gnt_idx,
  output logic            vld
);

  logic [IDXW-1:0] idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Modulo keeps the candidate inside 0..NREQ-1 for non power-of-two NREQ.
      idx = IDXW'((int'(ptr) + k) % NREQ);
      if (!vld && req[idx]) begin
        vld          = 1'b1;
        gnt_idx      = idx;
        gnt_oh[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_arbiter.sv
// Shares one external up/down counter among NREQ requesters, each needing a one-shot
// countdown of length L. Round-robin arbitration, counter load/enable control, and a
// one-cycle done pulse to the owner when the counter reaches terminal count.
// Optional build macro CDT_ARB_ABORT_EN: the owner dropping req in LOAD/RUN abandons
// the countdown (back to IDLE, no done). Without it the countdown always completes.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req[NREQ]        per-requester level request, held until done
//   req_len          packed lengths, slice i = [i*WIDTH +: WIDTH], sampled on arbitration only
//   gnt[NREQ]        one-hot owner, zero when idle
//   done[NREQ]       one-cycle completion pulse to the owner
//   busy             state is not IDLE
//   cnt_load/cnt_load_val/cnt_en/cnt_up_n_down  counter controls (direction fixed down)
//   cnt_tc           counter terminal count (count == 0 in down mode)
module countdown_timer_arbiter
  import cdt_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_load_val,
  output logic                  cnt_en,
  output logic                  cnt_up_n_down,
  input  logic                  cnt_tc
);

  cdt_state_e       state, state_nx;
  logic [IDXW-1:0]  owner, rr_ptr;
  logic [WIDTH-1:0] len_q, win_len;
  logic [NREQ-1:0]  win_oh, owner_oh;
  logic [IDXW-1:0]  win_idx;
  logic             win_vld;
  logic             abort;

  rr_arbiter_onehot #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .vld     (win_vld)
  );

  // One-hot mux of the winner's length.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQ; i++)
      if (win_oh[i]) win_len = win_len | req_len[i*WIDTH +: WIDTH];
  end

`ifdef CDT_ARB_ABORT_EN
  assign abort = ((state == LOAD) || (state == RUN)) && !req[owner];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_vld) state_nx = LOAD;
      LOAD:    state_nx = abort ? IDLE : RUN;
      RUN:     if (abort) state_nx = IDLE;
               else if (cnt_tc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      len_q  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && win_vld) begin
        owner <= win_idx;
        len_q <= win_len;
      end
      // Completed or abandoned owner drops to lowest priority.
      if ((state == DONE) || abort)
        rr_ptr <= IDXW'(rr_next_idx(int'(owner), NREQ));
    end
  end

  assign owner_oh      = NREQ'(1) << owner;
  assign busy          = (state != IDLE);
  assign gnt           = busy ? owner_oh : '0;
  assign done          = (state == DONE) ? owner_oh : '0;
  assign cnt_load      = (state == LOAD);
  assign cnt_load_val  = cnt_load ? len_q : '0;
  // Stop enabling at terminal count so the counter holds at 0 instead of wrapping.
  assign cnt_en        = (state == RUN) && !cnt_tc && !abort;
  assign cnt_up_n_down = 1'b0;

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
module tb_countdown_timer_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef CDT_ARB_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_len = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy, cnt_load, cnt_en, cnt_up_n_down, cnt_tc;
  logic [WIDTH-1:0]      cnt_load_val;
  logic [WIDTH-1:0]      cnt;

  always #5 clk = ~clk;

  countdown_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
    .cnt_up_n_down(cnt_up_n_down), .cnt_tc(cnt_tc)
  );

  // Environment: the shared universal counter, free-running wrap, same reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)        cnt <= '0;
    else if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_en)   cnt <= cnt_up_n_down ? cnt + 8'd1 : cnt - 8'd1;
  assign cnt_tc = cnt_up_n_down ? (cnt == 8'hFF) : (cnt == 8'h00);

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event logs of what the DUT did, for the directed literal checks.
  int load_cyc[$], load_own[$], load_val[$], done_cyc[$], done_own[$];
  int en_cnt;
  bit saw_ff;

  task automatic clear_logs();
    load_cyc.delete(); load_own.delete(); load_val.delete();
    done_cyc.delete(); done_own.delete();
    en_cnt = 0; saw_ff = 1'b0;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Transaction-level reference: a job started at arbitration occupies offsets
  // 1 (load), 2..L+2 (run), L+3 (done); enable is high for exactly L run cycles.
  bit  m_busy;
  int  m_owner, m_len, m_k, m_ptr;
  logic [NREQ-1:0]  e_gnt, e_done;
  logic             e_busy, e_load, e_en;
  logic [WIDTH-1:0] e_val;
  bit  ab;
  int  cand;

  initial begin
    m_busy = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_k = 0;
    forever begin
      @(negedge clk);
      e_gnt = '0; e_done = '0; e_busy = 0; e_load = 0; e_en = 0; e_val = '0;
      if (!rst_n) begin
        m_busy = 0; m_ptr = 0;
      end else if (m_busy) begin
        ab = ABORT && (m_k <= m_len + 2) && !req[m_owner];
        e_gnt  = NREQ'(1) << m_owner;
        e_busy = 1;
        e_load = (m_k == 1);
        e_val  = (m_k == 1) ? WIDTH'(m_len) : '0;
        e_en   = (m_k >= 2) && (m_k <= m_len + 1) && !ab;
        e_done = (m_k == m_len + 3) ? (NREQ'(1) << m_owner) : '0;
      end
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("done", 64'(done), 64'(e_done));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("cnt_load", 64'(cnt_load), 64'(e_load));
      chk("cnt_load_val", 64'(cnt_load_val), 64'(e_val));
      chk("cnt_en", 64'(cnt_en), 64'(e_en));
      chk("cnt_up_n_down", 64'(cnt_up_n_down), 64'd0);
      // advance the model to the next cycle
      if (rst_n) begin
        if (m_busy) begin
          if (ab || (m_k == m_len + 3)) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
          end else m_k++;
        end else if (|req) begin
          for (int j = 0; j < NREQ; j++) begin
            cand = (m_ptr + j) % NREQ;
            if (!m_busy && req[cand]) begin
              m_busy = 1; m_owner = cand; m_k = 1;
              m_len = int'(req_len[cand*WIDTH +: WIDTH]);
            end
          end
        end
      end
      // DUT-side event log
      if (cnt_load) begin
        load_cyc.push_back(cyc); load_own.push_back(oh_idx(gnt)); load_val.push_back(int'(cnt_load_val));
      end
      if (|done) begin
        done_cyc.push_back(cyc); done_own.push_back(oh_idx(done));
      end
      if (cnt_en) en_cnt++;
      if (cnt == 8'hFF) saw_ff = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int l);
    req_len[i*WIDTH +: WIDTH] = WIDTH'(l);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int c0, c1, c2, n2;

  initial begin
    step(1);
    do_reset();

    // single request, L=3 on requester 2
    clear_logs();
    set_len(2, 3); req[2] = 1'b1; c0 = cyc;
    step(7); req[2] = 1'b0; step(3);
    chk("t1_loads", load_cyc.size(), 1);
    chk("t1_dones", done_cyc.size(), 1);
    if (load_cyc.size() > 0) begin
      chk("t1_load_lat", load_cyc[0] - c0, 1);
      chk("t1_load_val", load_val[0], 3);
      chk("t1_load_own", load_own[0], 2);
    end
    if (done_cyc.size() > 0) begin
      chk("t1_done_lat", done_cyc[0] - c0, 6);
      chk("t1_done_own", done_own[0], 2);
    end
    chk("t1_en_cycles", en_cnt, 3);

    // all four requesting, L=1: round-robin order 0,1,2,3,0
    do_reset(); clear_logs();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = '1;
    step(27); req = '0; step(8);
    chk("t2_loads_ge5", load_own.size() >= 5, 1);
    if (load_own.size() >= 5) begin
      chk("t2_own0", load_own[0], 0);
      chk("t2_own1", load_own[1], 1);
      chk("t2_own2", load_own[2], 2);
      chk("t2_own3", load_own[3], 3);
      chk("t2_own4", load_own[4], 0);
      chk("t2_spacing", load_cyc[1] - load_cyc[0], 5);
    end

    // L=0 on requester 1: one RUN cycle, no enable, no wrap
    do_reset(); clear_logs();
    set_len(1, 0); req[1] = 1'b1; c0 = cyc;
    step(4); req[1] = 1'b0; step(3);
    chk("t3_dones", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t3_done_lat", done_cyc[0] - c0, 3);
    chk("t3_en_cycles", en_cnt, 0);
    chk("t3_no_wrap", saw_ff, 0);

    // length changed during RUN is ignored
    do_reset(); clear_logs();
    set_len(0, 5); req[0] = 1'b1; c0 = cyc;
    step(3); set_len(0, 9);
    step(6); req[0] = 1'b0; step(3);
    chk("t4_dones", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t4_done_lat", done_cyc[0] - c0, 8);
    chk("t4_en_cycles", en_cnt, 5);

    // reset mid-RUN; pointer returns to 0
    do_reset();
    set_len(2, 1); req[2] = 1'b1;
    step(5); req[2] = 1'b0; step(2);
    set_len(2, 8); req[2] = 1'b1; c1 = cyc;
    step(6);
    chk("t5_count_before_rst", cnt, 4);
    clear_logs();
    rst_n = 1'b0; #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_en", cnt_en, 0);
    chk("t5_rst_done", done, 0);
    step(2);
    rst_n = 1'b1; req = 4'b1010; set_len(1, 2); set_len(3, 2); c2 = cyc;
    step(8); req = '0; step(10);
    n2 = 0;
    foreach (done_own[i]) if (done_own[i] == 2) n2++;
    chk("t5_no_done2", n2, 0);
    if (load_own.size() > 0) begin
      chk("t5_first_own", load_own[0], 1);
      chk("t5_first_lat", load_cyc[0] - c2, 1);
    end else chk("t5_loads", load_own.size(), 1);

    // owner drops req in RUN cycle 2 of L=10
    do_reset(); clear_logs();
    set_len(3, 10); req[3] = 1'b1; c0 = cyc;
    step(1); set_len(0, 2); req[0] = 1'b1;
    step(2); req[3] = 1'b0;
    step(20); req = '0; step(8);
    n2 = 0;
    foreach (done_own[i]) if (done_own[i] == 3) n2++;
    chk("t6_loads_ge2", load_own.size() >= 2, 1);
    if (ABORT) begin
      chk("t6_no_done3", n2, 0);
      if (load_own.size() >= 2) begin
        chk("t6_next_own", load_own[1], 0);
        chk("t6_next_lat", load_cyc[1] - c0, 5);
      end
    end else begin
      chk("t6_done3", n2, 1);
      if (done_cyc.size() > 0) chk("t6_done_lat", done_cyc[0] - c0, 13);
      if (load_own.size() >= 2) begin
        chk("t6_next_own", load_own[1], 0);
        chk("t6_next_lat", load_cyc[1] - c0, 15);
      end
    end

    // randomized traffic against the model
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (!req[i]) set_len(i, $urandom_range(0, 6));
          req[i] = ~req[i];
        end
        if (done[i] && ($urandom_range(0, 3) != 0)) req[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) set_len(i, $urandom_range(0, 9));
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0; step(1); rst_n = 1'b1;
      end
      step(1);
    end
    req = '0; step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
